// File: rtl/div_array_sched.sv
// Round-robin sequencer for one shared 16/8 combinational divider array: accepts one
// operation, holds operands for SETTLE_CYCLES, then returns q/r tagged with the requester ID.
// Optional define DIV_OVF_CHECK_EN flags divide-by-zero / quotient overflow at accept time.
module div_array_sched #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_n,
    input  logic [7:0]  req0_d,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_n,
    input  logic [7:0]  req1_d,
    output logic [15:0] div_n,
    output logic [7:0]  div_d,
    input  logic [7:0]  div_q,
    input  logic [7:0]  div_r,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [7:0]  resp_q,
    output logic [7:0]  resp_r,
    output logic        resp_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      div_n_q, div_n_d;
    logic [7:0]       div_d_q, div_d_d;
    logic             owner_q, owner_d;
    logic             resp_valid_q, resp_valid_d;
    logic [7:0]       quo_q, quo_d;
    logic [7:0]       rem_q, rem_d;

    logic        grant0, grant1, accept;
    logic [15:0] sel_n;
    logic [7:0]  sel_d;

    // Only the arbitration winner sees ready, so valid & ready is the grant itself.
    always_comb begin
        grant0 = (state_q == S_IDLE) && req0_valid && (!req1_valid || !rr_ptr_q);
        grant1 = (state_q == S_IDLE) && req1_valid && (!req0_valid ||  rr_ptr_q);
        accept = grant0 || grant1;
        sel_n  = grant1 ? req1_n : req0_n;
        sel_d  = grant1 ? req1_d : req0_d;
    end

`ifdef DIV_OVF_CHECK_EN
    logic err_q, err_d;
    logic flag_q, flag_d;
`endif

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path infers a latch.
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        cnt_d        = cnt_q;
        div_n_d      = div_n_q;
        div_d_d      = div_d_q;
        owner_d      = owner_q;
        resp_valid_d = resp_valid_q;
        quo_d        = quo_q;
        rem_d        = rem_q;
`ifdef DIV_OVF_CHECK_EN
        err_d        = err_q;
        flag_d       = flag_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    div_n_d  = sel_n;
                    div_d_d  = sel_d;
                    owner_d  = grant1;
                    rr_ptr_d = !grant1;
                    cnt_d    = CNT_LOAD;
                    state_d  = S_WAIT;
`ifdef DIV_OVF_CHECK_EN
                    // Any case the 8-bit quotient cannot represent, decided on the sampled operands.
                    flag_d   = (sel_d == 8'd0) || (sel_n[15:8] >= sel_d);
`endif
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
`ifdef DIV_OVF_CHECK_EN
                    if (flag_q) begin
                        quo_d = 8'hFF;
                        rem_d = div_n_q[7:0];
                        err_d = 1'b1;
                    end else begin
                        quo_d = div_q;
                        rem_d = div_r;
                        err_d = 1'b0;
                    end
`else
                    quo_d = div_q;
                    rem_d = div_r;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q      <= S_IDLE;
            rr_ptr_q     <= 1'b0;
            cnt_q        <= '0;
            div_n_q      <= '0;
            div_d_q      <= '0;
            owner_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            quo_q        <= '0;
            rem_q        <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            cnt_q        <= cnt_d;
            div_n_q      <= div_n_d;
            div_d_q      <= div_d_d;
            owner_q      <= owner_d;
            resp_valid_q <= resp_valid_d;
            quo_q        <= quo_d;
            rem_q        <= rem_d;
        end
    end

`ifdef DIV_OVF_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q  <= 1'b0;
            flag_q <= 1'b0;
        end else begin
            err_q  <= err_d;
            flag_q <= flag_d;
        end
    end
    assign resp_err = err_q;
`else
    assign resp_err = 1'b0;
`endif

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign div_n      = div_n_q;
    assign div_d      = div_d_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = owner_q;
    assign resp_q     = quo_q;
    assign resp_r     = rem_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_div_array_sched.sv
// Directed bench for div_array_sched: an exact-divider instance (SETTLE_CYCLES=2) and a
// SETTLE_CYCLES=1 instance whose array model lags its operands by two cycles.
module tb_div_array_sched;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Main instance signals
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [15:0] req0_n, req1_n, div_n;
    logic [7:0]  req0_d, req1_d, div_d, div_q, div_r;
    logic        resp_valid, resp_ready, resp_id, resp_err, busy;
    logic [7:0]  resp_q, resp_r;
    logic [15:0] full_q;

    // SETTLE_CYCLES=1 instance signals
    logic        b_req0_valid, b_req0_ready, b_req1_ready;
    logic [15:0] b_req0_n, b_div_n;
    logic [7:0]  b_req0_d, b_div_d;
    logic        b_resp_valid, b_resp_id, b_resp_err, b_busy;
    logic [7:0]  b_resp_q, b_resp_r;
    logic [15:0] b_lag1_n = '0, b_lag2_n = '0;
    logic [7:0]  b_lag1_d = '0, b_lag2_d = '0;

    int tests = 0;
    int fails = 0;
    int lat;

    div_array_sched #(.SETTLE_CYCLES(2), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_n(req0_n), .req0_d(req0_d),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_n(req1_n), .req1_d(req1_d),
        .div_n(div_n), .div_d(div_d), .div_q(div_q), .div_r(div_r),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_q(resp_q), .resp_r(resp_r), .resp_err(resp_err), .busy(busy)
    );

    div_array_sched #(.SETTLE_CYCLES(1), .CNT_W(4)) dut_s1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_n(b_req0_n), .req0_d(b_req0_d),
        .req1_valid(1'b0), .req1_ready(b_req1_ready), .req1_n(16'd0), .req1_d(8'd0),
        .div_n(b_div_n), .div_d(b_div_d), .div_q(b_lag2_n[7:0]), .div_r(b_lag2_d),
        .resp_valid(b_resp_valid), .resp_ready(1'b1), .resp_id(b_resp_id),
        .resp_q(b_resp_q), .resp_r(b_resp_r), .resp_err(b_resp_err), .busy(b_busy)
    );

    // Exact divider array; divide-by-zero returns all-ones / low dividend byte.
    always_comb begin
        full_q = '0;
        div_q  = 8'hFF;
        div_r  = div_n[7:0];
        if (div_d != 8'd0) begin
            full_q = div_n / {8'd0, div_d};
            div_q  = full_q[7:0];
            div_r  = 8'(div_n % {8'd0, div_d});
        end
    end

    // Slow array: outputs follow the operands two edges late.
    always @(posedge clk) begin
        b_lag1_n <= b_div_n;
        b_lag2_n <= b_lag1_n;
        b_lag1_d <= b_div_d;
        b_lag2_d <= b_lag1_d;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until the selected instance shows resp_valid; lat = edges taken.
    task automatic wait_resp(input bit slow, output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            n++;
            if ((slow ? b_resp_valid : resp_valid) === 1'b1) break;
        end
        if ((slow ? b_resp_valid : resp_valid) !== 1'b1) check("resp_timeout", 0, 1);
    endtask

    // Requester 0 alone: check grant, accept, scramble inputs afterwards, wait for result.
    task automatic run_op0(input logic [15:0] n, input logic [7:0] d, input string tag);
        req1_valid = 1'b0;
        resp_ready = 1'b0;
        req0_n = n; req0_d = d; req0_valid = 1'b1;
        #1;
        check({tag, "_ready0"}, req0_ready, 1'b1);
        step();
        req0_valid = 1'b0;
        req0_n = ~n; req0_d = ~d;
        check({tag, "_div_n"}, div_n, n);
        wait_resp(1'b0, lat);
        check({tag, "_latency"}, lat, 2);
    endtask

    task automatic finish_resp(input string tag);
        resp_ready = 1'b1;
        step();
        check({tag, "_vld_clr"}, resp_valid, 1'b0);
        check({tag, "_idle"}, busy, 1'b0);
        resp_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 0; req1_valid = 0; resp_ready = 0;
        req0_n = 0; req0_d = 0; req1_n = 0; req1_d = 0;
        b_req0_valid = 0; b_req0_n = 0; b_req0_d = 0;
        step(); step();
        rst_n = 1'b1;
        step();

        // Reset state
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_id", resp_id, 0);
        check("rst_resp_q", resp_q, 0);
        check("rst_resp_r", resp_r, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", {req0_ready, req1_ready}, 0);
        check("rst_div_n", div_n, 0);
        check("rst_div_d", div_d, 0);

        // Single request: 100/7 = 14 r 2, inputs scrambled after accept
        run_op0(16'd100, 8'd7, "single");
        check("single_id", resp_id, 0);
        check("single_q", resp_q, 14);
        check("single_r", resp_r, 2);
        check("single_err", resp_err, 0);
        finish_resp("single");

        // Both valid continuously after reset: grants 0,1,0,1
        rst_n = 1'b0; step(); rst_n = 1'b1;
        req0_n = 16'd50; req0_d = 8'd5; req1_n = 16'd81; req1_d = 8'd9;
        req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("rr_ready0", req0_ready, (i % 2) == 0);
            check("rr_ready1", req1_ready, (i % 2) == 1);
            step();
            wait_resp(1'b0, lat);
            check("rr_latency", lat, 2);
            check("rr_id", resp_id, i % 2);
            check("rr_q", resp_q, ((i % 2) == 0) ? 10 : 9);
            check("rr_r", resp_r, 0);
            step();
            check("rr_vld_clr", resp_valid, 0);
        end
        req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
        step();

        // Backpressure with requester 1 waiting: held result, no turnaround on the handshake edge
        run_op0(16'd200, 8'd10, "bp");
        req1_n = 16'd300; req1_d = 8'd3; req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid", resp_valid, 1);
            check("bp_q_r_id", {resp_q, resp_r, 7'd0, resp_id}, {8'd20, 8'd0, 8'd0});
            check("bp_ready", {req0_ready, req1_ready}, 0);
            check("bp_busy", busy, 1);
        end
        resp_ready = 1'b1;
        step();
        check("bp_vld_clr", resp_valid, 0);
        check("bp_no_turnaround", div_n, 200);
        check("bp_ready1_next", req1_ready, 1);
        step();
        resp_ready = 1'b0;
        req1_valid = 1'b0;
        check("bp_accept1", div_n, 300);
        wait_resp(1'b0, lat);
        check("bp_lat1", lat, 2);
        check("bp_q1", {resp_id, resp_q, resp_r}, {1'b1, 8'd100, 8'd0});
        finish_resp("bp1");

        // Overflow / divide-by-zero handling
`ifdef DIV_OVF_CHECK_EN
        run_op0(16'h1234, 8'h00, "dz");
        check("dz_err_q_r", {resp_err, resp_q, resp_r}, {1'b1, 8'hFF, 8'h34});
        finish_resp("dz");
        run_op0(16'h0A00, 8'h0A, "ovf");
        check("ovf_err_q_r", {resp_err, resp_q, resp_r}, {1'b1, 8'hFF, 8'h00});
        finish_resp("ovf");
`else
        run_op0(16'h1234, 8'h00, "dz");
        check("dz_err_q_r", {resp_err, resp_q, resp_r}, {1'b0, 8'hFF, 8'h34});
        finish_resp("dz");
        run_op0(16'h0A00, 8'h0A, "ovf");
        check("ovf_err_q_r", {resp_err, resp_q, resp_r}, {1'b0, 8'h00, 8'h00});
        finish_resp("ovf");
`endif
        run_op0(16'h09FF, 8'h0A, "edge");
        check("edge_err_q_r", {resp_err, resp_q, resp_r}, {1'b0, 8'hFF, 8'h09});
        finish_resp("edge");

        // Reset on what would be the capture edge
        req0_n = 16'h1111; req0_d = 8'd3; req0_valid = 1'b1;
        step();
        req0_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid_rst_valid", resp_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_div", {div_n, div_d}, 0);
        step(); step(); step();
        check("mid_rst_no_resp", resp_valid, 0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("mid_rst_grant", {req0_ready, req1_ready}, 2'b10);
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();

        // SETTLE_CYCLES=1: capture one edge after accept sees the lagging array's old outputs
        b_req0_n = 16'h0011; b_req0_d = 8'h22; b_req0_valid = 1'b1;
        step();
        b_req0_valid = 1'b0;
        wait_resp(1'b1, lat);
        check("s1_lat_a", lat, 1);
        check("s1_first", {b_resp_q, b_resp_r}, 16'h0000);
        step();
        b_req0_n = 16'h5533; b_req0_d = 8'h44; b_req0_valid = 1'b1;
        step();
        b_req0_valid = 1'b0;
        wait_resp(1'b1, lat);
        check("s1_lat_b", lat, 1);
        check("s1_second", {b_resp_q, b_resp_r}, 16'h1122);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/div_array_sched.md
Name: div_array_sched

Overview:
- Sequencer and arbiter for one shared 16/8 combinational divider array (exact or approximate variant).
- Arbitrates round-robin between two requesters using valid/ready handshakes.
- Registers operands onto the array and holds them for a programmable settle window, then captures the quotient and remainder.
- Returns q/r tagged with the requester ID. One operation is in flight at a time.

Parameters:
SETTLE_CYCLES, 2, cycles the array operands are held before q/r are sampled; legal range 1..15
CNT_W, 4, width of the settle counter; must satisfy 2^CNT_W > SETTLE_CYCLES

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 accepted this cycle
req0_n  in  16  requester 0 dividend
req0_d  in  8  requester 0 divisor
req1_valid  in  1  requester 1 has an operation
req1_ready  out  1  requester 1 accepted this cycle
req1_n  in  16  requester 1 dividend
req1_d  in  8  requester 1 divisor
div_n  out  16  registered dividend driven to the array
div_d  out  8  registered divisor driven to the array
div_q  in  8  array quotient
div_r  in  8  array remainder
resp_valid  out  1  result available
resp_ready  in  1  consumer accepts result
resp_id  out  1  ID of the requester that owns the result
resp_q  out  8  quotient
resp_r  out  8  remainder
resp_err  out  1  divide-by-zero or quotient overflow (0 unless DIV_OVF_CHECK_EN)
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n low at a clk edge) values:
  - state = IDLE, rr_ptr = 0 (requester 0 preferred), counter = 0.
  - div_n = 0, div_d = 0.
  - resp_valid = 0, resp_id = 0, resp_q = 0, resp_r = 0, resp_err = 0.
  - busy = 0, req0_ready = 0, req1_ready = 0.
- Reset mid-operation: aborts immediately with no response. A held result is discarded.
- FSM state IDLE:
  - reqX_ready is combinational and high only for the arbitration winner.
  - If exactly one requester is valid, it wins.
  - If both are valid, the requester selected by rr_ptr wins. rr_ptr then points to the other requester.
  - A transfer occurs when valid & ready at an edge. At that edge:
    - div_n/div_d load the winner's operands.
    - The owner ID is latched.
    - counter = SETTLE_CYCLES-1.
    - The FSM goes to WAIT.
  - With no valid requester, the FSM stays in IDLE and rr_ptr is unchanged.
- FSM state WAIT:
  - Both ready outputs are 0.
  - div_n/div_d are held stable.
  - The counter decrements each edge.
  - At the edge where counter == 0, div_q/div_r are captured into resp_q/resp_r, resp_valid is set, and the FSM goes to RESP.
  - With SETTLE_CYCLES=1 the capture happens on the first edge after accept.
- Latency: accept at edge k gives resp_valid high after edge k+SETTLE_CYCLES. This is fixed and independent of operand values.
- FSM state RESP:
  - resp_* are held stable while resp_valid & !resp_ready.
  - At the edge with resp_ready high, resp_valid clears and the FSM returns to IDLE.
  - Ready outputs are 0 during RESP, so a new accept can occur one cycle after the response handshake at the earliest. There is no same-cycle turnaround.
- div_n/div_d keep their last value in IDLE and RESP. They are not cleared.
- Requester inputs are sampled only at the accept edge. Changing them afterwards has no effect.
- resp_ready high while resp_valid is low is ignored.
- A requester dropping valid before it is granted is legal. It is simply not served.

Optional Feature:
- Macro DIV_OVF_CHECK_EN, defined:
  - At accept, the block flags divide-by-zero (d == 0) and overflow (n[15:8] >= d). These cover every case where the 8-bit quotient cannot hold the result.
  - On a flagged operation: resp_err = 1, resp_q = 8'hFF, resp_r = n[7:0] of the accepted operands. div_q/div_r are ignored.
  - Latency is identical to the unflagged path; the WAIT count still runs.
  - Unflagged operations return the array outputs with resp_err = 0.
- Macro not defined:
  - No check logic is built. resp_err is tied 0.
  - Array outputs are always returned, whatever the operands.

Test Plan:
- Single request, SETTLE_CYCLES=2: req0 n=16'd100, d=8'd7, array model exact -> accepted at edge k; resp_valid after edge k+2; resp_id=0, q=14, r=2.
- Both requesters valid continuously after reset: req0 n=50,d=5 and req1 n=81,d=9 -> grant order 0,1,0,1; responses q=10,r=0 then q=9,r=0 alternate with matching resp_id.
- Backpressure: resp_ready held low 5 cycles -> resp_q/resp_r/resp_id stable, both readys 0, busy 1; resp_ready high -> IDLE; next accept no earlier than the following cycle.
- DIV_OVF_CHECK_EN: n=16'h1234, d=0 -> resp_err=1, q=FF, r=34. n=16'h0A00, d=8'h0A -> resp_err=1. n=16'h09FF, d=8'h0A -> resp_err=0, q=FF, r=9.
- Reset mid-WAIT: rst_n low one edge during WAIT -> next cycle resp_valid=0, busy=0, div_n=0, div_d=0; with both valid afterwards, requester 0 is granted first.
- SETTLE_CYCLES=1 build: array model whose outputs change 2 cycles after operands -> captured values are the pre-change outputs. This confirms sampling occurs exactly 1 edge after accept.
